// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: one outstanding slave transaction at a time,
// with an optional wait-cycle timeout that aborts the transfer and returns DEADBEEF.
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [29:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [29:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic [29:0] s_addr,
  output logic        s_we,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  input  logic        s_ready,
  input  logic [31:0] s_rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [15:0] r_wait_cnt;

  logic        w_grant;
  logic        w_sel_m1;
  logic        w_timeout;
  logic        w_done;
  logic [29:0] w_addr;
  logic        w_we;
  logic [31:0] w_wdata;
  logic [3:0]  w_wmask;
  logic [31:0] w_rdata;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    w_grant   = rst_n && (r_state == IDLE) && (m0_req || m1_req);
    w_sel_m1  = m1_req && (!m0_req || !r_last);
    w_addr    = w_sel_m1 ? m1_addr  : m0_addr;
    w_we      = w_sel_m1 ? m1_we    : m0_we;
    w_wdata   = w_sel_m1 ? m1_wdata : m0_wdata;
    w_wmask   = w_sel_m1 ? m1_wmask : m0_wmask;
    w_timeout = TO_EN && (r_wait_cnt == TO_LAST);
    w_done    = s_ready || w_timeout;
    w_rdata   = s_ready ? s_rdata : ABORT_DATA;
  end

  assign m0_gnt = w_grant && !w_sel_m1;
  assign m1_gnt = w_grant && w_sel_m1;
  assign s_req  = (r_state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_wait_cnt <= '0;
      s_addr     <= '0;
      s_we       <= 1'b0;
      s_wdata    <= '0;
      s_wmask    <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state    <= BUSY;
            r_owner    <= w_sel_m1;
            r_last     <= w_sel_m1;
            r_wait_cnt <= '0;
            s_addr     <= w_addr;
            s_we       <= w_we;
            s_wdata    <= w_wdata;
            s_wmask    <= w_wmask;
          end
        end
        BUSY: begin
          // s_ready takes priority over a coincident timeout.
          if (w_done) begin
            r_state <= IDLE;
            if (r_owner) begin
              m1_rvalid <= 1'b1;
              m1_err    <= !s_ready;
              m1_rdata  <= w_rdata;
            end else begin
              m0_rvalid <= 1'b1;
              m0_err    <= !s_ready;
              m0_rdata  <= w_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin/timeout reference model.
module tb_bus_arbiter;

  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [29:0] m0_addr, m1_addr;
  logic        m0_we, m1_we;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_err, m1_err;
  logic        s_req;
  logic [29:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;
  logic        s_ready;
  logic [31:0] s_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending requests, round-robin pointer, expected held outputs.
  bit          pend   [2];
  logic [29:0] p_addr [2];
  logic        p_we   [2];
  logic [31:0] p_wdata[2];
  logic [3:0]  p_wmask[2];
  int          last;
  logic [31:0] exp_rd [2];
  bit          have_prev;
  int          prev_own;
  bit          prev_err;
  logic [29:0] l_addr;
  logic        l_we;
  logic [31:0] l_wdata;
  logic [3:0]  l_wmask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    p_addr[i]  = 30'($urandom);
    p_we[i]    = 1'($urandom);
    p_wdata[i] = $urandom;
    p_wmask[i] = 4'($urandom);
  endtask

  task automatic drive_reqs();
    m0_req = pend[0]; m0_addr = p_addr[0]; m0_we = p_we[0];
    m0_wdata = p_wdata[0]; m0_wmask = p_wmask[0];
    m1_req = pend[1]; m1_addr = p_addr[1]; m1_we = p_we[1];
    m1_wdata = p_wdata[1]; m1_wmask = p_wmask[1];
  endtask

  // Completion outputs expected in the cycle after a transaction ends (or none).
  task automatic chk_prev();
    bit rv0, rv1;
    rv0 = have_prev && (prev_own == 0);
    rv1 = have_prev && (prev_own == 1);
    chk("m0_rvalid", m0_rvalid, rv0);
    chk("m1_rvalid", m1_rvalid, rv1);
    chk("m0_err", m0_err, rv0 && prev_err);
    chk("m1_err", m1_err, rv1 && prev_err);
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    chk("idle_s_req", s_req, 1'b0);
    chk("idle_s_addr", s_addr, l_addr);
    chk("idle_s_wdata", s_wdata, l_wdata);
  endtask

  // One transaction: w = index of the BUSY cycle carrying s_ready (>= TOUT means never).
  // inj 1: transient request by the other master during BUSY; inj 2: persistent one.
  task automatic txn(input int w, input logic [31:0] rd, input int inj);
    int win, oth, kend;
    bit terr;
    drive_reqs();
    @(negedge clk);
    chk_prev();
    win = (pend[0] && pend[1]) ? ((last == 1) ? 0 : 1) : (pend[1] ? 1 : 0);
    chk("m0_gnt", m0_gnt, win == 0);
    chk("m1_gnt", m1_gnt, win == 1);
    last = win;
    oth  = 1 - win;
    l_addr = p_addr[win]; l_we = p_we[win]; l_wdata = p_wdata[win]; l_wmask = p_wmask[win];
    pend[win] = 1'b0;
    kend = (w < TOUT) ? w : TOUT - 1;
    terr = (w >= TOUT);
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk); #1;
      if (inj == 2 && k == 0 && !pend[oth]) new_req(oth);
      drive_reqs();
      if (inj == 1 && k == 0 && !pend[oth]) begin
        if (oth == 1) m1_req = 1'b1; else m0_req = 1'b1;
      end
      s_ready = (k == w);
      s_rdata = (k == w) ? rd : $urandom;
      @(negedge clk);
      chk("busy_s_req", s_req, 1'b1);
      chk("busy_s_addr", s_addr, l_addr);
      chk("busy_s_we", s_we, l_we);
      chk("busy_s_wdata", s_wdata, l_wdata);
      chk("busy_s_wmask", s_wmask, l_wmask);
      chk("busy_gnt", {m1_gnt, m0_gnt}, 2'b00);
      chk("busy_rvalid", {m1_rvalid, m0_rvalid, m1_err, m0_err}, 4'b0000);
      chk("busy_m0_rdata", m0_rdata, exp_rd[0]);
      chk("busy_m1_rdata", m1_rdata, exp_rd[1]);
    end
    @(posedge clk); #1;
    s_ready = 1'b0;
    exp_rd[win] = terr ? 32'hDEADBEEF : rd;
    have_prev = 1'b1;
    prev_own  = win;
    prev_err  = terr;
  endtask

  task automatic drain();
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk_prev();
    chk("drain_gnt", {m1_gnt, m0_gnt}, 2'b00);
    @(posedge clk); #1;
    have_prev = 1'b0;
    @(negedge clk);
    chk_prev();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    last = 1; exp_rd[0] = '0; exp_rd[1] = '0; have_prev = 1'b0;
    l_addr = '0; l_we = 1'b0; l_wdata = '0; l_wmask = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_ready = 1'b0; s_rdata = '0;
    model_reset();
    prev_own = 0; prev_err = 1'b0;
    new_req(0); new_req(1);
    drive_reqs();
    @(negedge clk);
    chk_prev();
    chk("reset_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("reset_s_we_wmask", {s_we, s_wmask}, 5'b0);

    // First tie after reset goes to m0, then strict alternation with zero-wait slave.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (!pend[0]) new_req(0);
      if (!pend[1]) new_req(1);
      txn(0, $urandom, 0);
    end
    drain();

    // m1 read with three wait cycles.
    pend[1] = 1'b1; p_addr[1] = 30'h100; p_we[1] = 1'b0; p_wdata[1] = '0; p_wmask[1] = '0;
    txn(3, 32'h12345678, 0);
    drain();

    // Timeout abort, then s_ready arriving exactly in the timeout cycle.
    new_req(0);
    txn(9, 32'h0, 0);
    drain();
    new_req(0);
    txn(TOUT - 1, 32'hCAFEF00D, 0);
    drain();

    // m0 write; m1 raises its request mid-BUSY and is served afterwards.
    pend[0] = 1'b1; p_addr[0] = 30'h3; p_we[0] = 1'b1;
    p_wdata[0] = 32'hA5A5A5A5; p_wmask[0] = 4'b0011;
    txn(1, $urandom, 2);
    txn(0, $urandom, 0);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      txn(int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 1)));
    end
    drain();

    // Reset in the middle of a BUSY transaction.
    new_req(1);
    drive_reqs();
    @(negedge clk);
    chk_prev();
    chk("pre_rst_m1_gnt", m1_gnt, 1'b1);
    @(posedge clk); #1;
    pend[1] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk("pre_rst_s_req", s_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_s_req", s_req, 1'b0);
    chk("async_rst_s_addr", s_addr, 30'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_prev();
    @(posedge clk); #1;
    new_req(0); new_req(1);
    txn(0, $urandom, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, meaning BUSY cycles allowed before abort; 0 disables the timeout (range 0..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_req / m1_req  input  1  master 0 (fetch) / master 1 (data) request; held high until gnt.
REQ-005 m0_addr / m1_addr  input  30  word address.
REQ-006 m0_we / m1_we  input  1  write enable.
REQ-007 m0_wdata / m1_wdata  input  32  write data.
REQ-008 m0_wmask / m1_wmask  input  4  byte-lane write mask.
REQ-009 m0_gnt / m1_gnt  output  1  request accepted this cycle (combinational, one-cycle pulse).
REQ-010 m0_rvalid / m1_rvalid  output  1  transaction complete, one-cycle pulse.
REQ-011 m0_rdata / m1_rdata  output  32  read data; valid with rvalid.
REQ-012 m0_err / m1_err  output  1  timeout abort, one-cycle pulse coincident with rvalid.
REQ-013 s_req  output  1  transaction to slave bus (address decoder) active.
REQ-014 s_addr / s_we / s_wdata / s_wmask  output  30/1/32/4  latched transaction fields.
REQ-015 s_ready  input  1  slave completes the transaction this cycle.
REQ-016 s_rdata  input  32  slave read data; sampled when s_ready=1.

Function
REQ-017 FSM SHALL have two states: IDLE, BUSY.
REQ-018 IDLE: if any req=1, a winner SHALL be selected combinationally, its gnt asserted that cycle, its fields and ID latched at the edge, and the FSM SHALL move to BUSY.
REQ-019 Arbitration SHALL be round-robin: with one requester, it wins; with both, the master not granted last wins; the last-granted pointer SHALL reset to master 1, so master 0 wins the first tie.
REQ-020 gnt SHALL never be asserted in BUSY, and never for both masters in the same cycle.
REQ-021 BUSY: s_req=1 and s_addr/s_we/s_wdata/s_wmask SHALL hold the latched values, stable until completion.
REQ-022 On s_ready=1 in BUSY: s_rdata SHALL be registered into the owner's rdata; the owner's rvalid SHALL pulse the next cycle; the FSM SHALL return to IDLE at the same edge.
REQ-023 A new grant MAY occur in the same cycle as the previous rvalid pulse; back-to-back throughput SHALL be one transaction per 2 cycles with zero-wait slaves.
REQ-024 Minimum latency: req/gnt in cycle N, s_req in N+1, s_ready in N+1 -> rvalid in N+2.
REQ-025 A 16-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without s_ready.
REQ-026 If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without s_ready, the transaction SHALL abort: FSM to IDLE; owner rvalid and err pulse next cycle; rdata=32'hDEADBEEF.
REQ-027 If s_ready and the timeout occur in the same cycle, s_ready SHALL win (normal completion, err=0).
REQ-028 If req drops before gnt, the request SHALL be dropped with no side effect.
REQ-029 Outputs in IDLE SHALL be s_req=0; the s_* fields SHALL hold their last values.
REQ-030 rdata of a master SHALL hold its value until that master's next completion.
REQ-031 The non-owner's rvalid/err/rdata SHALL be unaffected by a completion.

Reset
REQ-032 While rst_n=0: FSM=IDLE; gnt, rvalid, err, s_req=0; s_addr, s_wdata=0; s_we=0; s_wmask=0; rdata=0; counter=0; pointer=master 1.
REQ-033 Reset asserted mid-BUSY SHALL abort immediately with no rvalid/err pulse after release.
REQ-034 The first grant SHALL be possible in the first cycle after rst_n rises.

Verification
REQ-035 Both req=1 after reset, s_ready=1 every cycle -> gnts alternate m0,m1,m0,m1; each rvalid 2 cycles after its gnt.
REQ-036 m1 read addr 30'h100, s_ready after 3 wait cycles with s_rdata=32'h12345678 -> s_addr=30'h100 stable 4 cycles; m1_rvalid=1 with m1_rdata=32'h12345678; m0 outputs unchanged.
REQ-037 TIMEOUT_CYCLES=4, s_ready held 0 -> s_req high 4 cycles; then m0_rvalid=m0_err=1 with m0_rdata=32'hDEADBEEF.
REQ-038 TIMEOUT_CYCLES=4, s_ready=1 in the timeout cycle -> normal completion, err=0, rdata=s_rdata.
REQ-039 m0 write addr 30'h3, wdata 32'hA5A5A5A5, wmask 4'b0011 -> exactly that beat on s_*; m1_req raised during BUSY is granted only in IDLE after completion.
REQ-040 rst_n pulsed low during BUSY -> s_req=0 asynchronously; no rvalid after release; next tie grants m0.
